// File: rtl/ram8_bist_if.sv
// Bus between the RAM8 BIST engine and its surroundings: test-controller
// handshake/results plus the RAM8 load/address/in/out port.
interface ram8_bist_if #(
    parameter int ADDR_W = 3
);
    logic              start;
    logic              mem_load;
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_in;
    logic [15:0]       mem_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_addr;
    logic [3:0]        err_count;

    modport master (
        input  start,
        input  mem_out,
        output mem_load,
        output mem_address,
        output mem_in,
        output busy,
        output done,
        output pass,
        output fail_addr,
        output err_count
    );

    modport slave (
        output start,
        output mem_out,
        input  mem_load,
        input  mem_address,
        input  mem_in,
        input  busy,
        input  done,
        input  pass,
        input  fail_addr,
        input  err_count
    );
endinterface

// File: rtl/ram8_bist.sv
// Four-pass march BIST (write P, read P, write ~P, read ~P) for one RAM8.
// Optional RAM8_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
//
// state | meaning
// IDLE  | after reset, waiting for start
// W0    | write pattern P(a)
// R0    | read, compare against P(a)
// W1    | write complement ~P(a)
// R1    | read, compare against ~P(a)
// DONE  | results held until start or reset
module ram8_bist #(
    parameter int          ADDR_W = 3,
    parameter logic [15:0] SEED   = 16'h5555
) (
    input  logic            clk,
    input  logic            reset,
    ram8_bist_if.master     bus
);
    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

    localparam logic [ADDR_W-1:0] A_LAST = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] a, a_nxt;
    logic              mism;
    logic              clear;
    logic [3:0]        err_nxt;

    function automatic logic [15:0] pat(input logic [ADDR_W-1:0] x);
        logic [15:0] wide;
        wide = 16'(x);
        return SEED ^ 16'(wide * 16'h1111);
    endfunction

    assign clear = ((state == IDLE) || (state == DONE)) && bus.start;

    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        mism      = 1'b0;
        err_nxt   = bus.err_count;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = W0;
                    a_nxt     = '0;
                end
            end
            W0: begin
                a_nxt = a + 1'b1;
                if (a == A_LAST) state_nxt = R0;
            end
            R0: begin
                mism  = (bus.mem_out != pat(a));
                a_nxt = a + 1'b1;
                if (a == A_LAST) state_nxt = W1;
            end
            W1: begin
                a_nxt = a + 1'b1;
                if (a == A_LAST) state_nxt = R1;
            end
            R1: begin
                mism  = (bus.mem_out != ~pat(a));
                a_nxt = a + 1'b1;
                if (a == A_LAST) state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
                a_nxt     = '0;
            end
        endcase
        if (mism && (bus.err_count != 4'hF)) err_nxt = bus.err_count + 4'd1;
`ifdef RAM8_BIST_STOP_ON_FAIL_EN
        if (mism) begin
            state_nxt = DONE;
            a_nxt     = '0;
        end
`endif
    end

    // Outputs are registered from the next-state values so the RAM sees the
    // W0/a=0 drive in the very cycle after start is sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            a               <= '0;
            bus.mem_load    <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_in      <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.pass        <= 1'b0;
            bus.fail_addr   <= '0;
            bus.err_count   <= '0;
        end else begin
            state           <= state_nxt;
            a               <= a_nxt;
            bus.mem_address <= a_nxt;
            bus.mem_load    <= (state_nxt == W0) || (state_nxt == W1);
            if (state_nxt == W0)
                bus.mem_in <= pat(a_nxt);
            else if (state_nxt == W1)
                bus.mem_in <= ~pat(a_nxt);
            bus.busy <= (state_nxt == W0) || (state_nxt == R0) ||
                        (state_nxt == W1) || (state_nxt == R1);
            bus.done <= (state_nxt == DONE);
            if (clear) begin
                bus.err_count <= '0;
                bus.fail_addr <= '0;
                bus.pass      <= 1'b0;
            end else begin
                bus.err_count <= err_nxt;
                if (mism && (bus.err_count == 4'd0)) bus.fail_addr <= a;
                bus.pass <= (state_nxt == DONE) && (err_nxt == 4'd0);
            end
        end
    end
endmodule

// File: tb/tb_ram8_bist.sv
// Randomized scoreboard bench for ram8_bist against a faultable RAM8 model.
module tb_ram8_bist;
    typedef struct {
        int err;
        int fail;
        int len;
    } exp_t;

`ifdef RAM8_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   e0cyc = 0;
    exp_t sb[$];

    // fault: 0 none, 1 stuck bit fb=fv in word fw, 2 address bit 2 ignored
    int   ftype = 0;
    int   fw = 0;
    int   fb = 0;
    logic fv = 1'b0;
    logic [15:0] ram [8];
    logic [15:0] rd_word;

    ram8_bist_if #(.ADDR_W(3)) bus ();

    ram8_bist #(.ADDR_W(3), .SEED(16'h5555)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int phys(input int x);
        return (ftype == 2) ? (x % 4) : x;
    endfunction

    function automatic logic [15:0] pat_i(input int x);
        return 16'h5555 ^ 16'(x * 32'h1111);
    endfunction

    always @(posedge clk)
        if (bus.mem_load) ram[phys(int'(bus.mem_address))] <= bus.mem_in;

    always_comb begin
        rd_word = ram[phys(int'(bus.mem_address))];
        if (ftype == 1 && int'(bus.mem_address) == fw) rd_word[fb] = fv;
        bus.mem_out = rd_word;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: march the whole test over a plain array with the fault applied.
    function automatic exp_t model_run();
        logic [15:0] m [8];
        logic [15:0] d, rd;
        bit stopped = 0;
        exp_t e;
        e.err = 0; e.fail = 0; e.len = 0;
        for (int p = 0; p < 4; p++)
            for (int x = 0; x < 8; x++) begin
                if (!stopped) begin
                    e.len++;
                    d = pat_i(x) ^ ((p >= 2) ? 16'hFFFF : 16'h0000);
                    if (p % 2 == 0) m[phys(x)] = d;
                    else begin
                        rd = m[phys(x)];
                        if (ftype == 1 && x == fw) rd[fb] = fv;
                        if (rd != d) begin
                            if (e.err == 0) e.fail = x;
                            if (e.err < 15) e.err++;
                            if (STOP) stopped = 1;
                        end
                    end
                end
            end
        return e;
    endfunction

    // Result monitor: pops the expectation when done rises.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.done && !prev_done) begin
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("run_length", cyc - e0cyc, e.len);
                chk("err_count", bus.err_count, e.err);
                chk("fail_addr", bus.fail_addr, e.fail);
                chk("pass", bus.pass, (e.err == 0));
                chk("busy_at_done", bus.busy, 0);
            end
        end
        prev_done = bus.done;
    end

    // Write-trace monitor: writes k=0..7 carry P(k), k=8..15 carry ~P(k-8).
    int wr_idx = 0;
    always @(negedge clk) begin
        if (reset || !bus.busy) wr_idx = 0;
        else if (bus.mem_load) begin
            chk("wr_addr", bus.mem_address, wr_idx % 8);
            chk("wr_data", bus.mem_in,
                pat_i(wr_idx % 8) ^ ((wr_idx >= 8) ? 16'hFFFF : 16'h0000));
            wr_idx++;
        end
    end

    task automatic set_fault(input int t, input int w, input int b, input logic v);
        ftype = t; fw = w; fb = b; fv = v;
    endtask

    task automatic issue_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 e0cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        chk("clr_busy", bus.busy, 1);
        chk("clr_done", bus.done, 0);
        chk("clr_err", bus.err_count, 0);
        chk("clr_fail", bus.fail_addr, 0);
        chk("clr_pass", bus.pass, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", bus.done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int t, input int w, input int b, input logic v);
        @(negedge clk);
        set_fault(t, w, b, v);
        sb.push_back(model_run());
        issue_start();
        wait_done();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_load"}, bus.mem_load, 0);
        chk({tag, "_addr"}, bus.mem_address, 0);
        chk({tag, "_in"}, bus.mem_in, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_pass"}, bus.pass, 0);
        chk({tag, "_fail"}, bus.fail_addr, 0);
        chk({tag, "_err"}, bus.err_count, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) ram[i] = 16'h0000;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run(0, 0, 0, 1'b0);       // fault-free
        run(1, 5, 0, 1'b0);       // word 5 bit 0 stuck-at-0
        run(2, 0, 0, 1'b0);       // address bit 2 ignored
        run(0, 0, 0, 1'b0);       // restart from a failing DONE

        // start held through busy, then reset mid-R0
        @(negedge clk);
        set_fault(0, 0, 0, 1'b0);
        sb.push_back(model_run());
        bus.start = 1'b1;
        @(posedge clk);
        #1 e0cyc = cyc;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("hold_busy", bus.busy, 1);
        chk("hold_load", bus.mem_load, 0);
        chk("hold_addr", bus.mem_address, 4);
        #2 reset = 1'b1;
        #1 chk_zero("async_rst");
        sb.delete();
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run(0, 0, 0, 1'b0);

        for (int r = 0; r < 8; r++)
            run($urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 15),
                1'($urandom_range(0, 1)));

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
